// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Two-master AHB arbiter (M1 = instruction side, M2 = data side) with a
//   default-master fallback when nobody requests. Grants are registered.
//   HMASTER/HMASTLOCK describe the address-phase owner, which trails the
//   grant by one completed transfer.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on a tie (the master that is not the
//                           last owner wins)
//              undefined -> fixed priority, M1 over M2
//
// Parameters:
//   MAX_TENURE  consecutive HREADY-high owned cycles before the owner must
//               yield at a burst boundary (2..255)
//
// Ports:
//   clk, rst                  bus clock, synchronous active-high reset
//   HREADY                    transfer complete; all state frozen while low
//   HBUSREQ_M1/M2             bus requests
//   HLOCK_M1/M2               locked-sequence requests
//   HTRANS_M1/M2              transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   HGRANT_M1/M2              registered grants, one-hot or zero
//   HMASTER                   address-phase owner (0 none, 1 M1, 2 M2)
//   HMASTLOCK                 address-phase transfer is locked
//
// Grant FSM:
//   state    | meaning
//   OWN_NONE | bus parked on the default master, no grant
//   OWN_M1   | M1 owns the bus
//   OWN_M2   | M2 owns the bus

module ahb_arbiter #(
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       HREADY,
  input  logic       HBUSREQ_M1,
  input  logic       HBUSREQ_M2,
  input  logic       HLOCK_M1,
  input  logic       HLOCK_M2,
  input  logic [1:0] HTRANS_M1,
  input  logic [1:0] HTRANS_M2,
  output logic       HGRANT_M1,
  output logic       HGRANT_M2,
  output logic [3:0] HMASTER,
  output logic       HMASTLOCK
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [7:0] TENURE_MAX    = 8'(MAX_TENURE);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2
  } owner_e;

  owner_e     grant_q, grant_d;
  owner_e     last_q, last_d;
  // Tenure is kept as cycles remaining: zero means the owner has used up
  // its MAX_TENURE allowance.
  logic [7:0] tenure_left_q, tenure_left_d;
  logic       gnt_m1_q, gnt_m2_q;
  logic [3:0] hmaster_q;
  logic       hmastlock_q;

  logic       oreq, olock;
  logic [1:0] otrans;
  logic       boundary, expired;
  logic       cand_m1, cand_m2;
  logic [7:0] tenure_tick;
  owner_e     pick;

  always_comb begin
    oreq   = 1'b0;
    olock  = 1'b0;
    otrans = HTRANS_IDLE;
    case (grant_q)
      OWN_M1: begin
        oreq   = HBUSREQ_M1;
        olock  = HLOCK_M1;
        otrans = HTRANS_M1;
      end
      OWN_M2: begin
        oreq   = HBUSREQ_M2;
        olock  = HLOCK_M2;
        otrans = HTRANS_M2;
      end
      default: ;
    endcase
  end

  assign boundary    = (otrans == HTRANS_IDLE) || (otrans == HTRANS_NONSEQ);
  assign expired     = (tenure_left_q == 8'd0);
  assign tenure_tick = expired ? 8'd0 : tenure_left_q - 8'd1;

  // An expired owner only steps aside if the other master actually wants
  // the bus; otherwise it may keep it.
  assign cand_m1 = HBUSREQ_M1 && !(expired && (grant_q == OWN_M1) && HBUSREQ_M2);
  assign cand_m2 = HBUSREQ_M2 && !(expired && (grant_q == OWN_M2) && HBUSREQ_M1);

  always_comb begin
    pick = OWN_NONE;
    if (cand_m1 && cand_m2) begin
`ifdef ARB_RR_EN
      pick = (last_q == OWN_M1) ? OWN_M2 : OWN_M1;
`else
      pick = OWN_M1;
`endif
    end else if (cand_m1) begin
      pick = OWN_M1;
    end else if (cand_m2) begin
      pick = OWN_M2;
    end
  end

  always_comb begin
    grant_d       = grant_q;
    last_d        = last_q;
    tenure_left_d = tenure_tick;
    if (olock) begin
      grant_d = grant_q;
    end else if (oreq && !expired) begin
      grant_d = grant_q;
    end else if (boundary) begin
      grant_d = pick;
      if (pick != grant_q) begin
        tenure_left_d = TENURE_MAX;
        if (pick != OWN_NONE) begin
          last_d = pick;
        end
      end
    end
    // Mid-burst (SEQ/BUSY) without lock: hold the grant until a boundary.
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= OWN_NONE;
      last_q        <= OWN_M2;
      tenure_left_q <= TENURE_MAX;
      gnt_m1_q      <= 1'b0;
      gnt_m2_q      <= 1'b0;
      hmaster_q     <= 4'd0;
      hmastlock_q   <= 1'b0;
    end else if (HREADY) begin
      grant_q       <= grant_d;
      last_q        <= last_d;
      tenure_left_q <= tenure_left_d;
      gnt_m1_q      <= (grant_d == OWN_M1);
      gnt_m2_q      <= (grant_d == OWN_M2);
      // Address phase follows the grant that was in force during this transfer.
      hmaster_q     <= {2'b00, grant_q};
      hmastlock_q   <= olock;
    end
  end

  assign HGRANT_M1 = gnt_m1_q;
  assign HGRANT_M2 = gnt_m2_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

  localparam int MAXT = 16;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, HREADY, HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2;
  logic [1:0] HTRANS_M1, HTRANS_M2;
  logic       HGRANT_M1, HGRANT_M2, HMASTLOCK;
  logic [3:0] HMASTER;

  always #5 clk = ~clk;

  ahb_arbiter #(.MAX_TENURE(MAXT)) dut (
    .clk(clk), .rst(rst), .HREADY(HREADY),
    .HBUSREQ_M1(HBUSREQ_M1), .HBUSREQ_M2(HBUSREQ_M2),
    .HLOCK_M1(HLOCK_M1), .HLOCK_M2(HLOCK_M2),
    .HTRANS_M1(HTRANS_M1), .HTRANS_M2(HTRANS_M2),
    .HGRANT_M1(HGRANT_M1), .HGRANT_M2(HGRANT_M2),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  typedef struct {
    logic       rst, hr, r1, r2, l1, l2;
    logic [1:0] t1, t2;
  } in_t;

  typedef struct {
    in_t        in;
    logic       g1, g2;
    logic [3:0] hm;
    logic       hl;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: owner 0/1/2, last owner, tenure counted upward.
  int m_g, m_l, m_t, m_hm, m_hl;

  function automatic in_t mk(input logic rs, hr, r1, r2, l1, l2,
                             input logic [1:0] t1, t2);
    in_t v;
    v.rst = rs; v.hr = hr; v.r1 = r1; v.r2 = r2;
    v.l1 = l1; v.l2 = l2; v.t1 = t1; v.t2 = t2;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t in, input logic g1, g2,
                               input logic [3:0] hm, input logic hl);
    vec_t v;
    v.in = in; v.g1 = g1; v.g2 = g2; v.hm = hm; v.hl = hl;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input in_t v);
    int oreq, olock, otrans, win, req_id, other_req, expired;
    int order[$];
    if (v.rst) begin
      m_g = 0; m_l = 2; m_t = 0; m_hm = 0; m_hl = 0;
    end else if (v.hr) begin
      oreq   = (m_g == 1) ? int'(v.r1) : (m_g == 2) ? int'(v.r2) : 0;
      olock  = (m_g == 1) ? int'(v.l1) : (m_g == 2) ? int'(v.l2) : 0;
      otrans = (m_g == 1) ? int'(v.t1) : (m_g == 2) ? int'(v.t2) : 0;
      m_hm = m_g;
      m_hl = olock;
      expired = (m_t >= MAXT);
      if (olock != 0 || (oreq != 0 && !expired) || !(otrans == 0 || otrans == 2)) begin
        if (m_t < MAXT) m_t++;
      end else begin
        // Walk masters in preference order; first eligible requester wins.
        order = {};
        if (RR) begin
          order.push_back((m_l == 1) ? 2 : 1);
          order.push_back(m_l);
        end else begin
          order.push_back(1);
          order.push_back(2);
        end
        win = 0;
        foreach (order[k]) begin
          req_id    = (order[k] == 1) ? int'(v.r1) : int'(v.r2);
          other_req = (order[k] == 1) ? int'(v.r2) : int'(v.r1);
          if (win == 0 && req_id != 0 && !(expired && m_g == order[k] && other_req != 0))
            win = order[k];
        end
        if (win != m_g) begin
          m_t = 0;
          if (win != 0) m_l = win;
          m_g = win;
        end else if (m_t < MAXT) begin
          m_t++;
        end
      end
    end
  endtask

  task automatic cmp_model();
    chk("gnt_m1", int'(HGRANT_M1), (m_g == 1) ? 1 : 0);
    chk("gnt_m2", int'(HGRANT_M2), (m_g == 2) ? 1 : 0);
    chk("hmaster", int'(HMASTER), m_hm);
    chk("hmastlock", int'(HMASTLOCK), m_hl);
    chk("gnt_onehot", int'(HGRANT_M1 & HGRANT_M2), 0);
  endtask

  task automatic apply(input in_t v);
    @(negedge clk);
    rst = v.rst; HREADY = v.hr;
    HBUSREQ_M1 = v.r1; HBUSREQ_M2 = v.r2;
    HLOCK_M1 = v.l1; HLOCK_M2 = v.l2;
    HTRANS_M1 = v.t1; HTRANS_M2 = v.t2;
    @(posedge clk);
    model_edge(v);
    #1;
    cmp_model();
  endtask

  task automatic drv(input logic rs, hr, r1, r2, l1, l2, input logic [1:0] t1, t2);
    apply(mk(rs, hr, r1, r2, l1, l2, t1, t2));
  endtask

  vec_t tbl[9];
  int   cnt;

  initial begin
    rst = 1'b1; HREADY = 1'b1;
    HBUSREQ_M1 = 1'b0; HBUSREQ_M2 = 1'b0;
    HLOCK_M1 = 1'b0; HLOCK_M2 = 1'b0;
    HTRANS_M1 = 2'b00; HTRANS_M2 = 2'b00;
    m_g = 0; m_l = 2; m_t = 0; m_hm = 0; m_hl = 0;

    //                 rst hr r1 r2 l1 l2 t1 t2         g1 g2 hm hl
    tbl[0] = mkv(mk(1, 1, 0, 0, 0, 0, 2'd0, 2'd0), 0, 0, 4'd0, 0);
    tbl[1] = mkv(mk(0, 1, 0, 1, 0, 0, 2'd0, 2'd0), 0, 1, 4'd0, 0);
    tbl[2] = mkv(mk(0, 1, 0, 1, 0, 0, 2'd0, 2'd2), 0, 1, 4'd2, 0);
    tbl[3] = mkv(mk(0, 1, 0, 0, 0, 0, 2'd0, 2'd0), 0, 0, 4'd2, 0);
    tbl[4] = mkv(mk(0, 1, 1, 1, 0, 0, 2'd0, 2'd0), 1, 0, 4'd0, 0);
    tbl[5] = mkv(mk(0, 1, 0, 0, 0, 0, 2'd0, 2'd0), 0, 0, 4'd1, 0);
    tbl[6] = mkv(mk(0, 1, 1, 1, 0, 0, 2'd0, 2'd0), !RR, RR, 4'd0, 0);
    tbl[7] = mkv(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0), !RR, RR, 4'd0, 0);
    tbl[8] = mkv(mk(1, 0, 1, 1, 0, 0, 2'd0, 2'd0), 0, 0, 4'd0, 0);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].in);
      chk($sformatf("vec%0d_g1", i), int'(HGRANT_M1), int'(tbl[i].g1));
      chk($sformatf("vec%0d_g2", i), int'(HGRANT_M2), int'(tbl[i].g2));
      chk($sformatf("vec%0d_hm", i), int'(HMASTER), int'(tbl[i].hm));
      chk($sformatf("vec%0d_hl", i), int'(HMASTLOCK), int'(tbl[i].hl));
    end

    // Owner drops its request mid-burst: grant held until a boundary.
    drv(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 1, 1, 0, 0, 2'd2, 2'd0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 1, 0, 0, 2'd3, 2'd0);
      chk("seq_hold_g1", int'(HGRANT_M1), 1);
    end
    drv(0, 1, 0, 1, 0, 0, 2'd0, 2'd0);
    chk("seq_end_g2", int'(HGRANT_M2), 1);

    // Tenure expiry: M1 keeps NONSEQ-requesting, M2 waiting.
    drv(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      drv(0, 1, 1, 1, 0, 0, 2'd2, 2'd0);
      if (HGRANT_M2) break;
      cnt++;
    end
    chk("tenure_len", cnt, MAXT);
    chk("tenure_g2", int'(HGRANT_M2), 1);

    // Locked owner never yields.
    drv(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 1, 0, 1, 0, 2'd0, 2'd0);
    for (int i = 0; i < 40; i++) drv(0, 1, 1, 1, 1, 0, 2'd2, 2'd0);
    chk("lock_g1", int'(HGRANT_M1), 1);
    chk("lock_hl", int'(HMASTLOCK), 1);

    // Wait states freeze everything while M2 requests.
    drv(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 1, 0, 0, 0, 2'd2, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 1, 0, 0, 2'd0, 2'd0);
      chk("wait_g1", int'(HGRANT_M1), 1);
      chk("wait_hm", int'(HMASTER), 1);
    end
    drv(0, 1, 0, 1, 0, 0, 2'd0, 2'd0);
    chk("wait_end_g2", int'(HGRANT_M2), 1);
    chk("wait_end_hm", int'(HMASTER), 1);
    drv(0, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    chk("wait_next_hm", int'(HMASTER), 2);

    // Reset while M2 is locked mid-burst, with HREADY low.
    drv(1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    drv(0, 1, 0, 1, 0, 1, 2'd0, 2'd0);
    drv(0, 1, 0, 1, 0, 1, 2'd0, 2'd2);
    drv(0, 1, 0, 1, 0, 1, 2'd0, 2'd3);
    chk("lockm2_hl", int'(HMASTLOCK), 1);
    drv(1, 0, 0, 1, 0, 1, 2'd0, 2'd3);
    chk("rst_g1", int'(HGRANT_M1), 0);
    chk("rst_g2", int'(HGRANT_M2), 0);
    chk("rst_hm", int'(HMASTER), 0);
    chk("rst_hl", int'(HMASTLOCK), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drv(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
